// File: rtl/ant_dp_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the ant datapath arbiter.
package ant_dp_arbiter_pkg;

  localparam int INSTRUCTION_WIDTH = 16;
  localparam int RESULT_WIDTH      = 8;
  localparam int ARB_STATE_WIDTH   = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_OP_IDLE  = 2'd0,
    ARB_OP_ISSUE = 2'd1,
    ARB_OP_HOLD  = 2'd2,
    ARB_OP_WAIT  = 2'd3
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ant_dp_arbiter_if.sv
// Bundle of requester-side and datapath-side handshake signals around the arbiter.
// master = the arbiter itself, slave = the surrounding ant FSMs plus datapath.
interface ant_dp_arbiter_if
  import ant_dp_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int INSTR_W = INSTRUCTION_WIDTH,
  parameter int RES_W   = RESULT_WIDTH
);

  localparam int GW = grant_width(NUM_REQ);

  logic [NUM_REQ-1:0]         req_start;
  logic [NUM_REQ*INSTR_W-1:0] req_instruction;
  logic [NUM_REQ-1:0]         req_finished;
  logic [NUM_REQ*RES_W-1:0]   req_result;
  logic                       start_dp;
  logic [INSTR_W-1:0]         instruction_dp;
  logic                       finished_dp;
  logic [RES_W-1:0]           result_dp;
  logic [GW-1:0]              grant_id;
  logic                       busy;

  modport master (
    input  req_start, req_instruction, finished_dp, result_dp,
    output req_finished, req_result, start_dp, instruction_dp, grant_id, busy
  );

  modport slave (
    output req_start, req_instruction, finished_dp, result_dp,
    input  req_finished, req_result, start_dp, instruction_dp, grant_id, busy
  );

endinterface

// File: rtl/ant_dp_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: finds the first pending requester
// strictly after last_grant, wrapping modulo NUM_REQ. Reusable by other schedulers.
module ant_dp_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      g,
  output logic               any
);

  logic [GW-1:0] idx;

  // Walk the ring starting just after the previous owner; the first hit wins.
  always_comb begin
    g   = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!any && pending[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
  end

endmodule

// File: rtl/ant_dp_arbiter.sv
// Shares one drawing/memory datapath between NUM_REQ ant requesters. Each
// requester's start is buffered, the datapath is granted round-robin, the
// two-cycle start handshake is replayed toward it and the result is routed back.
module ant_dp_arbiter
  import ant_dp_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int INSTR_W = INSTRUCTION_WIDTH,
  parameter int RES_W   = RESULT_WIDTH
) (
  input logic clock,
  input logic reset,
  ant_dp_arbiter_if.master bus
);

  localparam int GW = grant_width(NUM_REQ);

  arb_state_t state, state_next;

  logic [NUM_REQ-1:0]       pending;
  logic [NUM_REQ-1:0]       finished_q;
  logic [NUM_REQ-1:0]       capture;
  logic [INSTR_W-1:0]       instr_buf [NUM_REQ];
  logic [NUM_REQ*RES_W-1:0] result_q;
  logic [INSTR_W-1:0]       instr_q;
  logic [GW-1:0]            grant_q;
  logic [GW-1:0]            last_grant;
  logic [GW-1:0]            pick_g;
  logic                     pick_any;
  logic                     wait_armed;
  logic                     grant_fire;
  logic                     complete;
  logic                     start_c;
  logic                     busy_c;

  ant_dp_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .g          (pick_g),
    .any        (pick_any)
  );

  // A start is only accepted from an idle requester with nothing buffered, so
  // the second cycle of the two-cycle start (and any stray pulse) is ignored.
  always_comb begin
    capture = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      capture[i] = bus.req_start[i] && finished_q[i] && !pending[i];
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_OP_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake strobes; the first WAIT cycle ignores finished_dp
  // because the datapath may still show a stale idle flag from before the start.
  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    busy_c     = 1'b1;
    grant_fire = 1'b0;
    complete   = 1'b0;
    case (state)
      ARB_OP_IDLE: begin
        busy_c = 1'b0;
        if (pick_any && bus.finished_dp) begin
          grant_fire = 1'b1;
          state_next = ARB_OP_ISSUE;
        end
      end
      ARB_OP_ISSUE: begin
        start_c    = 1'b1;
        state_next = ARB_OP_HOLD;
      end
      ARB_OP_HOLD: begin
        start_c    = 1'b1;
        state_next = ARB_OP_WAIT;
      end
      ARB_OP_WAIT: begin
        if (wait_armed && bus.finished_dp) begin
          complete   = 1'b1;
          state_next = ARB_OP_IDLE;
        end
      end
      default: begin
        busy_c     = 1'b0;
        state_next = ARB_OP_IDLE;
      end
    endcase
  end

  // Per-requester buffers, owner bookkeeping and result routing. The owner's
  // result and finished flag update together so the requester sees a valid result.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending    <= '0;
      finished_q <= '1;
      result_q   <= '0;
      instr_q    <= '0;
      grant_q    <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      wait_armed <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        instr_buf[i] <= '0;
      end
    end else begin
      wait_armed <= (state == ARB_OP_WAIT);
      if (grant_fire) begin
        grant_q <= pick_g;
        instr_q <= instr_buf[pick_g];
      end
      if (complete) begin
        last_grant <= grant_q;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (capture[i]) begin
          pending[i]    <= 1'b1;
          finished_q[i] <= 1'b0;
          instr_buf[i]  <= bus.req_instruction[i*INSTR_W +: INSTR_W];
        end
        if (complete && (grant_q == GW'(i))) begin
          pending[i]    <= 1'b0;
          finished_q[i] <= 1'b1;
          result_q[i*RES_W +: RES_W] <= bus.result_dp;
        end
      end
    end
  end

  assign bus.req_finished   = finished_q;
  assign bus.req_result     = result_q;
  assign bus.start_dp       = start_c;
  assign bus.instruction_dp = instr_q;
  assign bus.grant_id       = grant_q;
  assign bus.busy           = busy_c;

endmodule

// File: tb/tb_ant_dp_arbiter.sv
// Self-checking bench for ant_dp_arbiter: directed scenarios with literal
// expectations plus randomized requesters checked every cycle against a
// transaction-age model of the arbiter.
module tb_ant_dp_arbiter;
  import ant_dp_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int IW = INSTRUCTION_WIDTH;
  localparam int RW = RESULT_WIDTH;
  localparam int GW = grant_width(N);

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  ant_dp_arbiter_if #(.NUM_REQ(N)) bus ();

  ant_dp_arbiter #(.NUM_REQ(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Datapath environment model
  logic [IW-1:0] dp_log[$];
  int            dp_start_cyc = -1;
  int            fixed_lat = 5;
  bit            random_lat = 1'b0;
  bit            dp_active = 1'b0;
  int            dp_cnt = 0;
  int            dp_cur_lat = 5;
  logic [IW-1:0] dp_instr = '0;

  // Reference model state
  bit            model_valid = 1'b0;
  logic [N-1:0]  m_pending;
  logic [N-1:0]  m_fin;
  logic [N*RW-1:0] m_res;
  logic [IW-1:0] m_buf [N];
  int            m_owner;
  int            m_last;
  int            m_age;

  int hold [N];

  function automatic logic [RW-1:0] dpResult(input logic [IW-1:0] instr);
    return instr[15:8] ^ instr[7:0] ^ 8'h8D;
  endfunction

  function automatic logic [N*IW-1:0] place(input int idx, input logic [IW-1:0] v);
    logic [N*IW-1:0] r;
    r = '0;
    r[idx*IW +: IW] = v;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Model advance: age 0 idle, 1-2 start cycles, 3 masked wait, >=4 may complete.
  task automatic modelStep();
    logic [N-1:0] cap;
    int idx;
    bit found;
    if (reset) begin
      m_pending = '0;
      m_fin     = '1;
      m_res     = '0;
      m_owner   = 0;
      m_last    = N - 1;
      m_age     = 0;
      for (int i = 0; i < N; i++) m_buf[i] = '0;
      model_valid = 1'b1;
      return;
    end
    if (!model_valid) return;
    for (int i = 0; i < N; i++) cap[i] = bus.req_start[i] && m_fin[i] && !m_pending[i];
    if (m_age >= 4 && bus.finished_dp) begin
      m_res[m_owner*RW +: RW] = bus.result_dp;
      m_fin[m_owner]     = 1'b1;
      m_pending[m_owner] = 1'b0;
      m_last = m_owner;
      m_age  = 0;
    end else if (m_age > 0) begin
      m_age++;
    end else if (m_pending != '0 && bus.finished_dp) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && m_pending[idx]) begin
          found   = 1'b1;
          m_owner = idx;
        end
      end
      m_age = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (cap[i]) begin
        m_pending[i] = 1'b1;
        m_fin[i]     = 1'b0;
        m_buf[i]     = bus.req_instruction[i*IW +: IW];
      end
    end
  endtask

  task automatic compareAll();
    bit exp_start;
    exp_start = (m_age == 1) || (m_age == 2);
    checkOutput("req_finished", 64'(bus.req_finished), 64'(m_fin));
    checkOutput("req_result", 64'(bus.req_result), 64'(m_res));
    checkOutput("start_dp", 64'(bus.start_dp), 64'(exp_start));
    checkOutput("busy", 64'(bus.busy), 64'(m_age != 0));
    checkOutput("grant_id", 64'(bus.grant_id), 64'(m_owner));
    if (exp_start) checkOutput("instruction_dp", 64'(bus.instruction_dp), 64'(m_buf[m_owner]));
  endtask

  task automatic dpStep();
    if (reset) begin
      dp_active = 1'b0;
      bus.finished_dp = 1'b1;
    end else if (!dp_active) begin
      if (bus.start_dp) begin
        dp_active    = 1'b1;
        dp_instr     = bus.instruction_dp;
        dp_log.push_back(bus.instruction_dp);
        dp_start_cyc = cyc;
        dp_cnt       = 0;
        dp_cur_lat   = random_lat ? int'($urandom_range(2, 8)) : fixed_lat;
        bus.finished_dp = 1'b0;
        bus.result_dp   = RW'($urandom);
      end
    end else begin
      dp_cnt++;
      if (dp_cnt >= dp_cur_lat) begin
        bus.finished_dp = 1'b1;
        bus.result_dp   = dpResult(dp_instr);
        dp_active       = 1'b0;
      end else begin
        bus.result_dp = RW'($urandom);
      end
    end
  endtask

  initial begin
    bus.finished_dp = 1'b1;
    bus.result_dp   = '0;
    forever begin
      @(negedge clock);
      dpStep();
    end
  end

  initial forever begin
    @(posedge clock);
    modelStep();
  end

  initial forever begin
    @(negedge clock);
    if (model_valid) compareAll();
  end

  // Drive a start on every requester in mask for ncyc cycles; t0 is the first start cycle.
  task automatic applyStimulus(input logic [N-1:0] mask, input logic [N*IW-1:0] instrs,
                               input int ncyc, output int t0);
    @(posedge clock); #1;
    t0 = cyc;
    bus.req_start       = mask;
    bus.req_instruction = instrs;
    repeat (ncyc) begin
      @(posedge clock); #1;
    end
    bus.req_start = '0;
  endtask

  task automatic waitFinished(input logic [N-1:0] mask, input int budget, output int done_cyc);
    int n;
    n = 0;
    @(negedge clock);
    while (((bus.req_finished & mask) != mask) && (n < budget)) begin
      @(negedge clock);
      n++;
    end
    checkOutput("wait_timeout", 64'(n >= budget), 64'(0));
    done_cyc = cyc;
  endtask

  task automatic doReset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    int t0, t1, done;
    logic [N-1:0] st;
    bus.req_start       = '0;
    bus.req_instruction = '0;
    for (int i = 0; i < N; i++) hold[i] = 0;

    // Reset values
    @(posedge clock);
    @(negedge clock);
    checkOutput("rst_req_finished", 64'(bus.req_finished), 64'hF);
    checkOutput("rst_start_dp", 64'(bus.start_dp), 64'h0);
    checkOutput("rst_busy", 64'(bus.busy), 64'h0);
    checkOutput("rst_grant_id", 64'(bus.grant_id), 64'h0);
    checkOutput("rst_req_result", 64'(bus.req_result), 64'h0);
    checkOutput("rst_instruction_dp", 64'(bus.instruction_dp), 64'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Single request, datapath finishes 5 cycles after start
    fixed_lat = 5;
    dp_log.delete();
    applyStimulus(4'b0001, place(0, 16'h1234), 2, t0);
    waitFinished(4'b0001, 100, done);
    checkOutput("single_dp_count", 64'(dp_log.size()), 64'd1);
    checkOutput("single_dp_instr", 64'(dp_log[0]), 64'h1234);
    checkOutput("single_start_offset", 64'(dp_start_cyc - t0), 64'd2);
    checkOutput("single_done_offset", 64'(done - t0), 64'd8);
    checkOutput("single_result", 64'(bus.req_result[7:0]), 64'hAB);

    // Contention from a fresh reset: order 0,1,2,3, then round two starts at 0
    doReset();
    dp_log.delete();
    applyStimulus(4'b1111, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 2, t0);
    waitFinished(4'b1111, 300, done);
    checkOutput("cont_dp_count", 64'(dp_log.size()), 64'd4);
    checkOutput("cont_order0", 64'(dp_log[0]), 64'h1111);
    checkOutput("cont_order1", 64'(dp_log[1]), 64'h2222);
    checkOutput("cont_order2", 64'(dp_log[2]), 64'h3333);
    checkOutput("cont_order3", 64'(dp_log[3]), 64'h4444);
    dp_log.delete();
    applyStimulus(4'b1111, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 2, t0);
    waitFinished(4'b1111, 300, done);
    checkOutput("round2_first", 64'(dp_log[0]), 64'hA000);
    checkOutput("round2_last", 64'(dp_log[3]), 64'hA003);
    checkOutput("round2_result3", 64'(bus.req_result[31:24]), 64'h2E);

    // Fairness: req 2 is served between req 1's two transactions
    dp_log.delete();
    applyStimulus(4'b0010, place(1, 16'h1B01), 2, t0);
    applyStimulus(4'b0100, place(2, 16'h2C02), 2, t1);
    waitFinished(4'b0010, 100, done);
    applyStimulus(4'b0010, place(1, 16'h1B02), 2, t0);
    waitFinished(4'b1111, 200, done);
    checkOutput("fair_dp_count", 64'(dp_log.size()), 64'd3);
    checkOutput("fair_order1", 64'(dp_log[1]), 64'h2C02);
    checkOutput("fair_order2", 64'(dp_log[2]), 64'h1B02);

    // Protocol violation: extra start from req 2 while it is pending
    dp_log.delete();
    applyStimulus(4'b0100, place(2, 16'h2D00), 2, t0);
    applyStimulus(4'b0100, place(2, 16'hDEAD), 1, t1);
    waitFinished(4'b0100, 100, done);
    repeat (10) @(negedge clock);
    checkOutput("viol_dp_count", 64'(dp_log.size()), 64'd1);
    checkOutput("viol_dp_instr", 64'(dp_log[0]), 64'h2D00);
    checkOutput("viol_result", 64'(bus.req_result[23:16]), 64'hA0);

    // Reset while req 3 owns the datapath in WAIT
    fixed_lat = 8;
    applyStimulus(4'b1000, place(3, 16'h3E00), 2, t0);
    repeat (3) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    checkOutput("midwait_busy", 64'(bus.busy), 64'd1);
    checkOutput("midwait_grant", 64'(bus.grant_id), 64'd3);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("postrst_req_finished", 64'(bus.req_finished), 64'hF);
    checkOutput("postrst_start_dp", 64'(bus.start_dp), 64'd0);
    checkOutput("postrst_busy", 64'(bus.busy), 64'd0);
    fixed_lat = 5;
    dp_log.delete();
    applyStimulus(4'b1000, place(3, 16'h7777), 2, t0);
    waitFinished(4'b1000, 100, done);
    checkOutput("postrst_dp_instr", 64'(dp_log[0]), 64'h7777);
    checkOutput("postrst_result", 64'(bus.req_result[31:24]), 64'h8D);

    // Randomized requesters and datapath latency, one reset in the middle
    random_lat = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      reset = (c == 200);
      st = bus.req_start;
      for (int i = 0; i < N; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
        end else if ($urandom_range(0, 7) == 0) begin
          st[i] = 1'b1;
          bus.req_instruction[i*IW +: IW] = IW'($urandom);
          hold[i] = int'($urandom_range(0, 2));
        end else begin
          st[i] = 1'b0;
        end
      end
      bus.req_start = st;
    end
    @(posedge clock); #1;
    reset = 1'b0;
    bus.req_start = '0;
    waitFinished(4'b1111, 1000, done);
    repeat (5) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
